// File: rtl/bcd_time_counter.sv
// bcd_time_counter: two-field MM:SS BCD counter for the stopwatch datapath.
// Advances only on single-cycle enable strobes in the in_clock domain:
//   run mode    - in_tick counts seconds with carry into minutes, pulsing out_wrap
//                 when the minutes field rolls over
//   adjust mode - in_tick_adj steps the selected field alone, with no carry
// in_pause toggles the pause state; in_clear is a synchronous clear.
// Optional feature macro: COUNTDOWN_EN enables down counting through in_down,
// a sticky out_done flag and an automatic stop when the count reaches 00:00.
// When COUNTDOWN_EN is undefined, in_down is ignored and out_done is held at 0.
`timescale 1ns/1ps

module bcd_time_counter #(
  parameter int SEC_MAX   = 59,
  parameter int MIN_MAX   = 99,
  parameter bit PAUSE_RST = 1'b0
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_tick,
  input  logic       in_tick_adj,
  input  logic       in_clear,
  input  logic       in_pause,
  input  logic       in_adjust,
  input  logic       in_select,
  input  logic       in_down,
  output logic [3:0] out_sec0,
  output logic [3:0] out_sec1,
  output logic [3:0] out_min0,
  output logic [3:0] out_min1,
  output logic       out_paused,
  output logic       out_wrap,
  output logic       out_done
);

  // One BCD field: a tens digit and a ones digit.
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
  } field_t;

  localparam field_t SEC_TOP = '{tens: 4'(SEC_MAX / 10), ones: 4'(SEC_MAX % 10)};
  localparam field_t MIN_TOP = '{tens: 4'(MIN_MAX / 10), ones: 4'(MIN_MAX % 10)};
  localparam field_t F_ZERO  = '{tens: 4'd0, ones: 4'd0};
  localparam field_t F_ONE   = '{tens: 4'd0, ones: 4'd1};

  // Step a field up by one. The terminal value wraps to 00, so the field
  // can never go above top.
  function automatic field_t f_inc(input field_t f, input field_t top);
    field_t r;
    r = f;
    if (f == top) begin
      r = F_ZERO;
    end else if (f.ones == 4'd9) begin
      r.tens = f.tens + 4'd1;
      r.ones = 4'd0;
    end else begin
      r.ones = f.ones + 4'd1;
    end
    return r;
  endfunction

  // Step a field down by one. 00 wraps to the terminal value.
  function automatic field_t f_dec(input field_t f, input field_t top);
    field_t r;
    r = f;
    if (f == F_ZERO) begin
      r = top;
    end else if (f.ones == 4'd0) begin
      r.tens = f.tens - 4'd1;
      r.ones = 4'd9;
    end else begin
      r.ones = f.ones - 4'd1;
    end
    return r;
  endfunction

  field_t sec_q, min_q;
  field_t sec_n, min_n;
  logic   paused_n, wrap_n;
  logic   down, run_step, adj_step, done_lock;
  logic   done_q;

`ifdef COUNTDOWN_EN
  logic   done_n;
  logic   adj_q;   // in_adjust from the previous edge, used to detect entry into adjust mode
  assign down      = in_down;
  assign done_lock = done_q & out_paused;
`else
  // in_down is read but has no effect: the counter only counts up.
  assign down      = in_down & 1'b0;
  assign done_q    = 1'b0;
  assign done_lock = 1'b0;
`endif

  // A run tick only counts in run mode, when running and not finished.
  // An adjust tick works in adjust mode even while paused.
  assign run_step = ~in_adjust & in_tick & ~out_paused & ~done_q;
  assign adj_step =  in_adjust & in_tick_adj;

  // Next-state logic. Priority: clear, then the count or adjust step.
  // The pause toggle is evaluated on every edge.
  always_comb begin
    sec_n    = sec_q;
    min_n    = min_q;
    paused_n = out_paused;
    wrap_n   = 1'b0;
`ifdef COUNTDOWN_EN
    done_n   = done_q;
`endif
    // A finished countdown cannot be unpaused with the pause pulse.
    if (in_pause && !done_lock) paused_n = ~out_paused;

    if (adj_step) begin
      if (in_select) sec_n = down ? f_dec(sec_q, SEC_TOP) : f_inc(sec_q, SEC_TOP);
      else           min_n = down ? f_dec(min_q, MIN_TOP) : f_inc(min_q, MIN_TOP);
    end else if (run_step) begin
      if (down) begin
        sec_n = f_dec(sec_q, SEC_TOP);
        if (sec_q == F_ZERO) min_n = f_dec(min_q, MIN_TOP);
`ifdef COUNTDOWN_EN
        // 00:01 -> 00:00 finishes the countdown. The forced pause
        // overrides any toggle on this same edge.
        if (min_q == F_ZERO && sec_q == F_ONE) begin
          done_n   = 1'b1;
          paused_n = 1'b1;
        end
`endif
      end else begin
        sec_n = f_inc(sec_q, SEC_TOP);
        if (sec_q == SEC_TOP) begin
          min_n = f_inc(min_q, MIN_TOP);
          if (min_q == MIN_TOP) wrap_n = 1'b1;
        end
      end
    end

`ifdef COUNTDOWN_EN
    // Entering adjust mode releases a finished countdown.
    if (in_adjust && !adj_q) done_n = 1'b0;
`endif

    // Clear overrides everything, including the pause toggle.
    if (in_clear) begin
      sec_n    = F_ZERO;
      min_n    = F_ZERO;
      paused_n = PAUSE_RST;
      wrap_n   = 1'b0;
`ifdef COUNTDOWN_EN
      done_n   = 1'b0;
`endif
    end
  end

  // State and output registers, with asynchronous reset.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      sec_q      <= F_ZERO;
      min_q      <= F_ZERO;
      out_paused <= PAUSE_RST;
      out_wrap   <= 1'b0;
`ifdef COUNTDOWN_EN
      done_q     <= 1'b0;
      adj_q      <= 1'b0;
`endif
    end else begin
      sec_q      <= sec_n;
      min_q      <= min_n;
      out_paused <= paused_n;
      out_wrap   <= wrap_n;
`ifdef COUNTDOWN_EN
      done_q     <= done_n;
      adj_q      <= in_adjust;
`endif
    end
  end

  assign out_sec0 = sec_q.ones;
  assign out_sec1 = sec_q.tens;
  assign out_min0 = min_q.ones;
  assign out_min1 = min_q.tens;
  assign out_done = done_q;

endmodule
